signed_divider_module: RTL and testbench

SIGNED_DIVIDER_MODULE -- requirements
Module: signed_divider_module

---
 rtl/signed_divider_module.sv | 127 ++++++++++++
 tb/tb_signed_divider_module.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/signed_divider_module.sv
// Sequential signed divider: 16-bit dividend by 8-bit divisor, one restoring step per cycle.
// Operates on magnitudes and applies the operand signs in a final fix-up cycle.
module signed_divider_module (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] acc_q, acc_d;  // dividend bits shift out of the top, quotient bits in at the bottom
    logic [7:0]  dvs_q, dvs_d;
    logic [8:0]  rem_q, rem_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [15:0] quotient_q, quotient_d;
    logic [7:0]  remainder_q, remainder_d;
    logic        dbz_q, dbz_d;

    logic [9:0]  rem_shift;
    logic [9:0]  trial;

    always_comb begin
        rem_shift   = {rem_q, acc_q[15]};
        trial       = rem_shift - {2'b00, dvs_q};

        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = dividend[15] ? (~dividend + 16'd1) : dividend;
                    dvs_d   = divisor[7] ? (~divisor + 8'd1) : divisor;
                    rem_d   = 9'd0;
                    cnt_d   = 4'd0;
                    q_neg_d = dividend[15] ^ divisor[7];
                    r_neg_d = dividend[15];
                    if (divisor == 8'd0) begin
                        quotient_d  = 16'd0;
                        remainder_d = 8'd0;
                        dbz_d       = 1'b1;
                        state_d     = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                // A clear sign bit on the trial subtraction means the divisor fits.
                if (!trial[9]) begin
                    rem_d = trial[8:0];
                    acc_d = {acc_q[14:0], 1'b1};
                end else begin
                    rem_d = rem_shift[8:0];
                    acc_d = {acc_q[14:0], 1'b0};
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                quotient_d  = q_neg_q ? (~acc_q + 16'd1) : acc_q;
                remainder_d = r_neg_q ? (~rem_q[7:0] + 8'd1) : rem_q[7:0];
                dbz_d       = 1'b0;
                state_d     = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            acc_q       <= 16'd0;
            dvs_q       <= 8'd0;
            rem_q       <= 9'd0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= 16'd0;
            remainder_q <= 8'd0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == StCalc) || (state_q == StFix);
    assign done        = (state_q == StDone);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_signed_divider_module.sv
// Self-checking bench for signed_divider_module: directed corner cases plus random
// operands compared against plain truncating integer division.
module tb_signed_divider_module;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    signed_divider_module dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: language-level signed division truncates toward zero, % follows dividend sign.
    function automatic void ref_div(input logic [15:0] a, input logic [7:0] b,
                                    output logic [15:0] q, output logic [7:0] r,
                                    output logic z);
        int sa;
        int sb;
        int qi;
        int ri;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            q = 16'd0;
            r = 8'd0;
            z = 1'b1;
        end else begin
            qi = sa / sb;
            ri = sa % sb;
            q  = qi[15:0];
            r  = ri[7:0];
            z  = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] a, input logic [7:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
    endtask

    // Edges counted after the start-sampling edge until done is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] eq, input logic [7:0] er,
                             input logic ez);
        check({tag, ".done"}, {31'd0, done}, 32'd1);
        check({tag, ".q"}, {16'd0, quotient}, {16'd0, eq});
        check({tag, ".r"}, {24'd0, remainder}, {24'd0, er});
        check({tag, ".dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
        check({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er, input logic ez);
        int lat;
        launch(a, b);
        if (b != 8'd0) begin
            check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        end
        wait_done(lat);
        check({tag, ".latency"}, lat, (b == 8'd0) ? 32'd0 : 32'd17);
        check_out(tag, eq, er, ez);
        tick();
        check({tag, ".done_low"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;

        // Reset wins over a simultaneous start.
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 16'd510;
        divisor  = 8'd34;
        tick();
        tick();
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.q", {16'd0, quotient}, 32'd0);
        check("rst.r", {24'd0, remainder}, 32'd0);
        check("rst.dbz", {31'd0, div_by_zero}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("rst.idle_after", {31'd0, busy}, 32'd0);

        do_div("d510_34", 16'd510, 8'd34, 16'h000F, 8'h00, 1'b0);
        do_div("dm1180_59", 16'hFB64, 8'd59, 16'hFFEC, 8'h00, 1'b0);
        do_div("dm16129_127", 16'hC0FF, 8'd127, 16'hFF81, 8'h00, 1'b0);
        do_div("d1000_m7", 16'd1000, 8'hF9, 16'hFF72, 8'h06, 1'b0);
        do_div("dm1000_7", 16'hFC18, 8'd7, 16'hFF72, 8'hFA, 1'b0);
        do_div("d127_m128", 16'd127, 8'h80, 16'h0000, 8'h7F, 1'b0);
        do_div("ovf_m1", 16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0);
        do_div("m32768_m128", 16'h8000, 8'h80, 16'h0100, 8'h00, 1'b0);
        do_div("dbz_1234", 16'd1234, 8'd0, 16'h0000, 8'h00, 1'b1);
        do_div("after_dbz", 16'd100, 8'd3, 16'd33, 8'd1, 1'b0);

        // New operands pulsed mid-calculation must be ignored.
        launch(16'd510, 8'd34);
        repeat (5) tick();
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        tick();
        start    = 1'b0;
        wait_done(lat);
        check_out("ign_start", 16'h000F, 8'h00, 1'b0);
        tick();

        // Start held high: ignored while busy, restarts on the first idle cycle.
        launch(16'd100, 8'd3);
        start    = 1'b1;
        dividend = 16'd7;
        divisor  = 8'd2;
        wait_done(lat);
        check("hold.latency", lat, 32'd17);
        check_out("hold1", 16'd33, 8'd1, 1'b0);
        tick();
        check("hold.idle", {31'd0, busy}, 32'd0);
        tick();
        check("hold.restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done(lat);
        check("hold2.latency", lat, 32'd17);
        check_out("hold2", 16'd3, 8'd1, 1'b0);
        tick();

        // Reset abandons a division in progress.
        do_div("pre_rst", 16'hFC18, 8'd7, 16'hFF72, 8'hFA, 1'b0);
        launch(16'd510, 8'd34);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        check("midrst.busy", {31'd0, busy}, 32'd0);
        check("midrst.done", {31'd0, done}, 32'd0);
        check("midrst.q", {16'd0, quotient}, 32'd0);
        check("midrst.r", {24'd0, remainder}, 32'd0);
        check("midrst.dbz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;
        tick();
        do_div("post_rst", 16'd510, 8'd34, 16'h000F, 8'h00, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            a = 16'($urandom);
            b = 8'($urandom);
            if (b == 8'd0) b = 8'd1;
            if (a == 16'h8000 && b == 8'hFF) b = 8'hFE;
            ref_div(a, b, eq, er, ez);
            do_div("rand", a, b, eq, er, ez);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
